// File: rtl/shift_pkg.sv
// Shared definitions for the serial deserializer: FSM states, bit-order
// encodings and the default frame width.
package shift_pkg;

   // Receiver states: waiting for a start bit, collecting data, checking stop
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      STOP = 2'd2
   } state_t;

   // Bit-order selection as sampled from the dir input
   localparam logic DIR_MSB = 1'b0;
   localparam logic DIR_LSB = 1'b1;

   // Default number of data bits per frame
   localparam int WIDTH_DEFAULT = 4;

endpackage

// File: rtl/deser_hold.sv
// Output holding register with a valid/ready handshake. A delivered word is
// accepted when the register is empty or being drained in the same cycle;
// otherwise the new word is dropped and an overrun pulse is raised.
module deser_hold
   import shift_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             deliver_i,
   input  logic [WIDTH-1:0] word_i,
   input  logic             ready_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             valid_o,
   output logic             overrun_o
);

   logic [WIDTH-1:0] dout_q, dout_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;

   // Next-state of the holding register: load, drop-with-overrun, or drain
   always_comb begin
      dout_d  = dout_q;
      valid_d = valid_q;
      ovr_d   = 1'b0;
      if (deliver_i) begin
         if (!valid_q || ready_i) begin
            dout_d  = word_i;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Holding register state, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign dout_o    = dout_q;
   assign valid_o   = valid_q;
   assign overrun_o = ovr_q;

endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel deserializer: start bit, WIDTH data bits in a per-frame
// selectable bit order, then a stop bit. Good frames are handed to the
// holding register; bad stop bits raise a one-cycle frame error.
module shift_deser
   import shift_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             bit_en,
   input  logic             dir,
   input  logic             dout_ready,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] shreg_q;
   logic             dir_q;
   logic             busy_q;
   logic             ferr_q;
   logic             deliver;

   // A good stop bit hands the assembled word over on the same edge
   assign deliver = (state_q == STOP) && bit_en && sin;

   // Receive FSM with counter, shift register and registered status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         dir_q   <= DIR_MSB;
         busy_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         ferr_q <= 1'b0;
         if (bit_en) begin
            case (state_q)
               IDLE: begin
                  if (!sin) begin
                     state_q <= DATA;
                     cnt_q   <= '0;
                     dir_q   <= dir;
                     busy_q  <= 1'b1;
                  end
               end
               DATA: begin
                  if (dir_q == DIR_MSB) begin
                     shreg_q <= {shreg_q[WIDTH-2:0], sin};
                  end else begin
                     shreg_q <= {sin, shreg_q[WIDTH-1:1]};
                  end
                  // Counter parks on the last index; the frame moves on to STOP
                  if (cnt_q == CNT_LAST) begin
                     state_q <= STOP;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               STOP: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  ferr_q  <= !sin;
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   deser_hold #(
      .WIDTH(WIDTH)
   ) u_hold (
      .clk       (clk),
      .rst       (rst),
      .deliver_i (deliver),
      .word_i    (shreg_q),
      .ready_i   (dout_ready),
      .dout_o    (dout),
      .valid_o   (dout_valid),
      .overrun_o (overrun)
   );

   assign busy      = busy_q;
   assign frame_err = ferr_q;

endmodule

// File: tb/tb_shift_deser.sv
// Directed bench for shift_deser with a frame-level reference model.
module tb_shift_deser;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         sin;
   logic         bit_en;
   logic         dir;
   logic         dout_ready;
   logic [W-1:0] dout;
   logic         dout_valid;
   logic         busy;
   logic         frame_err;
   logic         overrun;

   int n_vec = 0;
   int n_bad = 0;

   // Expected outputs
   logic [W-1:0] ed;
   logic         ev, eb, ef, eo;
   // Pending delivery announced by the frame driver for the next edge
   logic         dlv;
   logic [W-1:0] dlv_word;

   always #5 clk = ~clk;

   shift_deser #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .sin        (sin),
      .bit_en     (bit_en),
      .dir        (dir),
      .dout_ready (dout_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy),
      .frame_err  (frame_err),
      .overrun    (overrun)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("dout",       32'(dout),       32'(ed));
      chk("dout_valid", 32'(dout_valid), 32'(ev));
      chk("busy",       32'(busy),       32'(eb));
      chk("frame_err",  32'(frame_err),  32'(ef));
      chk("overrun",    32'(overrun),    32'(eo));
   endtask

   task automatic model_reset();
      ed = '0; ev = 1'b0; eb = 1'b0; ef = 1'b0; eo = 1'b0; dlv = 1'b0; dlv_word = '0;
   endtask

   // Word value from the data bits in transmission order (tx[W-1] sent first)
   function automatic logic [W-1:0] word_of(input logic [W-1:0] tx, input logic d);
      logic [W-1:0] w;
      for (int i = 0; i < W; i++) w[i] = d ? tx[W-1-i] : tx[i];
      return w;
   endfunction

   // One clock: apply handshake rules to the model, advance, compare everything
   task automatic cyc();
      if (dlv) begin
         if (!ev || dout_ready) begin
            ed = dlv_word;
            ev = 1'b1;
         end else begin
            eo = 1'b1;
         end
      end else if (ev && dout_ready) begin
         ev = 1'b0;
      end
      @(posedge clk);
      #1;
      check_all();
      ef  = 1'b0;
      eo  = 1'b0;
      dlv = 1'b0;
   endtask

   // Full frame; per = bit_en period; dir input flipped after the start bit
   task automatic send_frame(input logic [W-1:0] tx, input logic d, input logic stopb,
                             input logic rdy, input int per);
      logic [W+1:0] sym;
      sym = {1'b0, tx, stopb};
      for (int k = 0; k < W + 2; k++) begin
         logic s;
         s = sym[W+1-k];
         for (int g = 1; g < per; g++) begin
            bit_en = 1'b0; sin = ~s; dout_ready = 1'b0; dir = ~d;
            cyc();
         end
         bit_en     = 1'b1;
         sin        = s;
         dir        = (k == 0) ? d : ~d;
         dout_ready = (k == W + 1) ? rdy : 1'b0;
         eb         = (k < W + 1);
         if (k == W + 1) begin
            if (stopb) begin
               dlv      = 1'b1;
               dlv_word = word_of(tx, d);
            end else begin
               ef = 1'b1;
            end
         end
         cyc();
      end
      bit_en = 1'b0; sin = 1'b1; dout_ready = 1'b0; dir = 1'b0;
   endtask

   task automatic consume();
      bit_en = 1'b0; sin = 1'b1; dout_ready = 1'b1;
      cyc();
      dout_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b0; sin = 1'b1; bit_en = 1'b0; dir = 1'b0; dout_ready = 1'b0;
      model_reset();
      #2;
      check_all();
      chk("reset_dout", 32'(dout), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc();
      cyc();

      // MSB first, data 1100, consumer not ready
      send_frame(4'b1100, 1'b0, 1'b1, 1'b0, 1);
      chk("msb_dout",  32'(dout),       32'hC);
      chk("msb_valid", 32'(dout_valid), 32'h1);
      consume();
      chk("drain_valid", 32'(dout_valid), 32'h0);

      // LSB first, line bits 0,0,0,1,1,1
      send_frame(4'b0011, 1'b1, 1'b1, 1'b0, 1);
      chk("lsb_dout", 32'(dout), 32'hC);
      consume();

      // Bad stop bit
      send_frame(4'b1010, 1'b0, 1'b0, 1'b0, 1);
      chk("ferr_valid", 32'(dout_valid), 32'h0);
      cyc();

      // Overrun, then replacement with ready at the stop edge (back-to-back)
      send_frame(4'b1100, 1'b0, 1'b1, 1'b0, 1);
      send_frame(4'b0011, 1'b0, 1'b1, 1'b0, 1);
      chk("ovr_dout", 32'(dout), 32'hC);
      send_frame(4'b0011, 1'b0, 1'b1, 1'b1, 1);
      chk("repl_dout",  32'(dout),       32'h3);
      chk("repl_valid", 32'(dout_valid), 32'h1);
      consume();

      // Reset after two data bits, then a clean frame
      bit_en = 1'b1; sin = 1'b0; dir = 1'b0; dout_ready = 1'b0; eb = 1'b1;
      cyc();
      sin = 1'b1;
      cyc();
      sin = 1'b0;
      cyc();
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      rst = 1'b1; bit_en = 1'b0; sin = 1'b1;
      cyc();
      send_frame(4'b1001, 1'b0, 1'b1, 1'b0, 1);
      chk("rst_dout", 32'(dout), 32'h9);
      consume();

      // Slow strobe: bit_en every 3rd cycle
      send_frame(4'b0110, 1'b0, 1'b1, 1'b0, 3);
      chk("slow_dout", 32'(dout), 32'h6);
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/shift_deser.md
SHIFT_DESER -- requirements
Module: shift_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of data bits per frame, at least 2.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port sin, input, 1 bit: serial line; idles high.
REQ-005 SHALL have port bit_en, input, 1 bit: bit strobe; sin is sampled only on clk edges where bit_en=1.
REQ-006 SHALL have port dir, input, 1 bit: bit order; 0 = MSB first, 1 = LSB first.
REQ-007 SHALL have port dout_ready, input, 1 bit: consumer accepts dout.
REQ-008 SHALL have port dout, output, WIDTH bits: received word.
REQ-009 SHALL have port dout_valid, output, 1 bit: dout holds an unconsumed word.
REQ-010 SHALL have port busy, output, 1 bit: high in DATA or STOP.
REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-012 SHALL have port overrun, output, 1 bit: one-cycle pulse when a good frame is dropped.

Function
REQ-013 SHALL implement the states IDLE, DATA and STOP.
REQ-014 IDLE: if bit_en=1 and sin=0 (start bit), SHALL go to DATA, clear the bit counter and latch dir into dir_q; otherwise SHALL stay in IDLE.
REQ-015 DATA: on each bit_en=1, SHALL shift the received bit into shreg.
- dir_q=0: shreg <= {shreg[WIDTH-2:0], sin}.
- dir_q=1: shreg <= {sin, shreg[WIDTH-1:1]}.
REQ-016 DATA: after the WIDTH-th data bit, SHALL go to STOP; the counter SHALL run 0..WIDTH-1 with no wrap beyond.
REQ-017 A dir change during a frame SHALL have no effect; dir_q holds for the whole frame.
REQ-018 STOP, bit_en=1, sin=1: SHALL attempt delivery (REQ-020..022) and go to IDLE.
REQ-019 STOP, bit_en=1, sin=0: SHALL pulse frame_err for one cycle, discard shreg, leave dout/dout_valid unchanged, and go to IDLE.
REQ-020 On delivery with dout_valid=0, SHALL load dout <= shreg and set dout_valid=1 on the same edge.
REQ-021 On delivery with dout_valid=1 and dout_ready=1 in the same cycle, SHALL load the new word, keep dout_valid=1, and not pulse overrun.
REQ-022 On delivery with dout_valid=1 and dout_ready=0, SHALL keep the old dout, drop the new word, and pulse overrun for one cycle.
REQ-023 dout_valid and dout_ready both high with no delivery SHALL clear dout_valid on that edge.
REQ-024 While dout_valid=1 and dout_ready=0, dout SHALL stay stable.
REQ-025 With bit_en=0, SHALL hold state, counter and shreg.
REQ-026 Latency: dout_valid SHALL rise on the same edge that samples a good stop bit.
REQ-027 Back-to-back frames: a start bit SHALL be accepted on the first bit_en after the stop bit.

Reset
REQ-028 rst=0 SHALL force, asynchronously:
- state=IDLE, counter=0, shreg=0, dir_q=0
- dout=0, dout_valid=0, busy=0, frame_err=0, overrun=0
REQ-029 Reset mid-frame SHALL abandon the frame with no error or overrun pulse; reception restarts on the next start bit after rst=1.

Structure
REQ-030 A shared package shift_pkg SHALL hold:
- the state enum (IDLE/DATA/STOP)
- the DIR_MSB=0 and DIR_LSB=1 constants
- the default WIDTH=4
REQ-031 The output holding register and handshake logic SHALL be one sub-module, deser_hold; the FSM, counter and shreg stay in shift_deser.

Verification
REQ-032 The bench SHALL cover: dir=0, bits 0,1,1,0,0,1 (start, data 1100, stop), dout_ready=0 -> dout=4'b1100, dout_valid=1 on the stop edge.
REQ-033 The bench SHALL cover: dir=1, bits 0,0,0,1,1,1 -> dout=4'b1100.
REQ-034 The bench SHALL cover: frame with data 1010 and stop bit 0 -> one-cycle frame_err, dout_valid remains 0.
REQ-035 The bench SHALL cover: word 1100 held unread, second frame 0011 with dout_ready=0 -> overrun pulse, dout stays 1100; repeated with dout_ready=1 at the stop edge -> dout=0011, no overrun.
REQ-036 The bench SHALL cover: rst=0 after 2 data bits, then a full frame 1001 -> dout=4'b1001, no frame_err.
REQ-037 The bench SHALL cover: bit_en toggling every 3rd cycle with frame 0110 -> dout=4'b0110; busy high from the start-bit edge to the stop-bit edge.
